// File: rtl/seq_det_pkg.sv
// seq_det_pkg: FSM state encoding and default widths shared by the sequence detector files
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_PAT_W = 4;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial match core (clk, rst, clr, bit_valid, bit_in, pattern -> hit); hit reflects the history after bit_in is shifted in
module seq_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] hist, nh;
  logic [FW-1:0] fill, nf;
  always_comb begin
    nh = PAT_W'({hist, bit_in});
    nf = fill == FW'(PAT_W) ? fill : fill + 1'b1;
    hit = bit_valid && nh == pattern && nf == FW'(PAT_W);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= nh;
      fill <= nf;
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: shifts accepted words LSB-first into seq_match_core and returns per-word hit counts; ports in_* accept handshake, ser_* bit stream, match_pulse, res_* result handshake, busy; SEQ_DET_STREAM_EN keeps match history across words
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W = DEF_PAT_W,
  localparam int CNT_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [PAT_W-1:0]  cfg_pattern,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              match_pulse,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy
);
  state_t state, nstate;
  logic [WORD_W-1:0] sreg;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] idx;
  logic acc, hit, clr;
  always_comb begin
    in_ready = state == IDLE;
    ser_valid = state == SHIFT;
    res_valid = state == DONE;
    busy = state != IDLE;
    ser_bit = ser_valid & sreg[0];
    acc = in_ready & in_valid;
    nstate = state;
    if (acc) nstate = SHIFT;
    else if (ser_valid && idx == CNT_W'(WORD_W - 1)) nstate = DONE;
    else if (res_valid && res_ready) nstate = IDLE;
  end
`ifdef SEQ_DET_STREAM_EN
  assign clr = 1'b0;
`else
  assign clr = acc;
`endif
  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bit_valid(ser_valid),
    .bit_in(ser_bit),
    .pattern(pat),
    .hit(hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sreg <= '0;
      pat <= '0;
      idx <= '0;
      res_count <= '0;
      match_pulse <= 1'b0;
    end else begin
      state <= nstate;
      match_pulse <= hit;
      if (acc) begin
        sreg <= in_word;
        pat <= cfg_pattern;
        idx <= '0;
        res_count <= '0;
      end else if (ser_valid) begin
        sreg <= sreg >> 1;
        idx <= idx + 1'b1;
        res_count <= res_count + CNT_W'(hit);
      end
    end
endmodule
